seq_detect_ctrl: RTL and testbench

Frame-level controller for the serial Mealy sequence detector. It accepts parallel data words over a valid/ready handshake and clears the detector before each word. It then shifts the word into the detector MSB-first, one bit per clock, and samples the detector output on every shifted bit. For each word it reports the match count and the position of the first match. It sits between the word-oriented datapath and the bit-serial detector.

---
 rtl/seq_detect_ctrl.sv | 129 ++++++++++++
 tb/tb_seq_detect_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_ctrl.sv
// Frame controller for a bit-serial Mealy sequence detector: accepts a word,
// clears the detector, shifts the word MSB-first and reports match count/position.
//
// state  | meaning
// IDLE   | waiting for a frame, in_ready=1
// CLEAR  | one-cycle detector clear
// SHIFT  | WIDTH cycles, one frame bit per clock into the detector
// REPORT | result held on out_* until out_ready
module seq_detect_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNTW  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             det_d_in,
    output logic             det_clr,
    input  logic             det_d_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNTW-1:0]  out_count,
    output logic             out_hit,
    output logic [CNTW-1:0]  out_pos,
    output logic [15:0]      total_hits,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        SHIFT  = 2'd2,
        REPORT = 2'd3
    } state_t;

    localparam logic [CNTW-1:0] LAST_IDX = CNTW'(WIDTH - 1);
    localparam logic [CNTW-1:0] CNT_MAX  = {CNTW{1'b1}};

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  shreg, shreg_nxt;
    logic [CNTW-1:0]   bit_idx, idx_nxt;
    logic [CNTW-1:0]   count, count_nxt;
    logic [CNTW-1:0]   pos, pos_nxt;
    logic              first_flag, first_nxt;
    logic [15:0]       hits, hits_nxt;
    logic              d_in_q, d_in_nxt;
    logic              clr_q, clr_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_idx    <= '0;
            count      <= '0;
            pos        <= '0;
            first_flag <= 1'b0;
            hits       <= '0;
            d_in_q     <= 1'b0;
            clr_q      <= 1'b0;
        end else begin
            state      <= state_nxt;
            shreg      <= shreg_nxt;
            bit_idx    <= idx_nxt;
            count      <= count_nxt;
            pos        <= pos_nxt;
            first_flag <= first_nxt;
            hits       <= hits_nxt;
            d_in_q     <= d_in_nxt;
            clr_q      <= clr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        idx_nxt   = bit_idx;
        count_nxt = count;
        pos_nxt   = pos;
        first_nxt = first_flag;
        hits_nxt  = hits;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    shreg_nxt = in_data;
                    idx_nxt   = '0;
                    count_nxt = '0;
                    pos_nxt   = '0;
                    first_nxt = 1'b0;
                    state_nxt = CLEAR;
                end
            end
            CLEAR: state_nxt = SHIFT;
            SHIFT: begin
                // det_d_out is the Mealy output for the bit currently on det_d_in
                if (det_d_out) begin
                    if (count != CNT_MAX) count_nxt = count + CNTW'(1);
                    if (!first_flag) begin
                        pos_nxt   = bit_idx;
                        first_nxt = 1'b1;
                    end
                    if (hits != 16'hFFFF) hits_nxt = hits + 16'd1;
                end
                shreg_nxt = {shreg[WIDTH-2:0], 1'b0};
                idx_nxt   = bit_idx + CNTW'(1);
                if (bit_idx == LAST_IDX) state_nxt = REPORT;
            end
            REPORT: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Serial bit and clear are precomputed so both leave the block straight from flops
    always_comb begin
        d_in_nxt = (state_nxt == SHIFT) ? shreg_nxt[WIDTH-1] : 1'b0;
        clr_nxt  = (state_nxt == CLEAR);
    end

    assign det_d_in   = d_in_q;
    assign det_clr    = clr_q;
    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == REPORT);
    assign busy       = (state != IDLE);
    assign out_count  = count;
    assign out_hit    = (count != '0);
    assign out_pos    = pos;
    assign total_hits = hits;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl with an overlapping "1011" Mealy detector model.
module tb_seq_detect_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       det_d_in;
    logic       det_clr;
    logic       det_d_out;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_count;
    logic       out_hit;
    logic [3:0] out_pos;
    logic [15:0] total_hits;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    seq_detect_ctrl #(.WIDTH(8), .CNTW(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .det_d_in   (det_d_in),
        .det_clr    (det_clr),
        .det_d_out  (det_d_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_count  (out_count),
        .out_hit    (out_hit),
        .out_pos    (out_pos),
        .total_hits (total_hits),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Overlapping "1011" detector: 0 none, 1 "1", 2 "10", 3 "101"
    logic [1:0] dst;
    always_comb det_d_out = (dst == 2'd3) && det_d_in;
    always @(posedge clk or negedge reset) begin
        if (!reset)       dst <= 2'd0;
        else if (det_clr) dst <= 2'd0;
        else begin
            case (dst)
                2'd0: dst <= det_d_in ? 2'd1 : 2'd0;
                2'd1: dst <= det_d_in ? 2'd1 : 2'd2;
                2'd2: dst <= det_d_in ? 2'd3 : 2'd0;
                default: dst <= det_d_in ? 2'd1 : 2'd2;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // Offers a frame, returns negedges from accept edge until out_valid is seen
    task automatic do_frame(input logic [7:0] d, output int lat);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic wait_result(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(tag, out_valid, 1);
    endtask

    initial begin
        int lat, k, rdy_n, clr_n, rep_n, first_rdy, second_rdy;
        logic ok;
        reset = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_valid", out_valid, 0);
        reset = 1'b1;

        // Reset mid-SHIFT at bit 4 of 8'hB6
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'hB6;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_hits_before", total_hits, 1);
        check("mid_busy_before", busy, 1);
        #1 reset = 1'b0;
        #1;
        check("mid_rst_state", {busy, in_ready, out_valid, det_clr, det_d_in}, 5'b01000);
        check("mid_rst_result", {out_hit, out_count, out_pos}, 9'd0);
        check("mid_rst_hits", total_hits, 0);
        @(negedge clk);
        reset = 1'b1;
        ok = 1'b1;
        repeat (15) begin
            @(negedge clk);
            if (out_valid) ok = 1'b0;
        end
        check("mid_no_valid", ok, 1);
        check("mid_hits_after", total_hits, 0);

        // 8'hB6: latency and first result
        do_frame(8'hB6, lat);
        check("b6_latency", lat, 10);
        check("b6_count", out_count, 2);
        check("b6_hit", out_hit, 1);
        check("b6_pos", out_pos, 3);
        check("b6_hits", total_hits, 2);

        // 8'hAB then 8'h00 from reset
        apply_reset();
        do_frame(8'hAB, lat);
        check("ab_count", out_count, 1);
        check("ab_pos", out_pos, 7);
        do_frame(8'h00, lat);
        check("zero_count", out_count, 0);
        check("zero_hit", out_hit, 0);
        check("zero_pos", out_pos, 0);
        check("ab_zero_hits", total_hits, 1);

        // Back-to-back 8'hBB frames
        apply_reset();
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'hBB; out_ready = 1'b1;
        rdy_n = 0; clr_n = 0; rep_n = 0; first_rdy = -1; second_rdy = -1;
        for (int n = 0; n < 22; n++) begin
            if (n > 0) @(negedge clk);
            if (in_ready) begin
                rdy_n++;
                if (first_rdy < 0) first_rdy = n;
                else second_rdy = n;
            end
            if (det_clr) clr_n++;
            if (out_valid) begin
                rep_n++;
                check("b2b_count", out_count, 2);
                check("b2b_pos", out_pos, 3);
            end
        end
        in_valid = 1'b0;
        check("b2b_ready_cnt", rdy_n, 2);
        check("b2b_period", second_rdy - first_rdy, 11);
        check("b2b_clr_cnt", clr_n, 2);
        check("b2b_reports", rep_n, 2);
        check("b2b_hits", total_hits, 4);

        // REPORT held with out_ready=0
        @(negedge clk);
        out_ready = 1'b0;
        do_frame(8'hB6, lat);
        check("hold_latency", lat, 10);
        in_valid = 1'b1; in_data = 8'hAB;
        ok = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (!(out_valid && out_count == 4'd2 && out_pos == 4'd3 && out_hit
                  && !in_ready && !det_d_in)) ok = 1'b0;
        end
        check("hold_stable", ok, 1);
        out_ready = 1'b1;
        @(negedge clk);
        check("rel_idle_ready", in_ready, 1);
        check("rel_idle_busy", busy, 0);
        @(negedge clk);
        check("rel_accept_clr", det_clr, 1);
        in_valid = 1'b0;
        wait_result("rel_result_valid");
        check("rel_count", out_count, 1);
        check("rel_pos", out_pos, 7);
        check("rel_hits", total_hits, 7);

        // in_valid raised during SHIFT is held off until IDLE
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'h00;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        in_valid = 1'b1; in_data = 8'hBB;
        check("shift_ready", in_ready, 0);
        k = 0;
        while (busy && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("shift_wait", k, 7);
        check("shift_idle_ready", in_ready, 1);
        @(negedge clk);
        check("shift_accept_clr", det_clr, 1);
        in_valid = 1'b0;
        wait_result("shift_result_valid");
        check("shift_count", out_count, 2);
        check("shift_pos", out_pos, 3);
        check("shift_hits", total_hits, 9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
